uart_top: RTL and testbench

Memory-mapped 8N1 UART peripheral for the TRSQ8 SoC. It sits on the shared 8-bit peripheral bus beside the SPI, GPIO and IIC blocks, at default window 0xA0–0xA3. It provides one TX holding/shift path, one RX byte buffer with error flags, and a 16-bit programmable bit-period divider.

---
 rtl/uart_top_pkg.sv | 28 ++
 rtl/uart_top_if.sv | 11 +
 rtl/uart_rx_core.sv | 78 +++++++
 rtl/uart_top.sv | 140 ++++++++++++++
 tb/tb_uart_top.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_top_pkg.sv
// Shared definitions for the 8N1 UART: register offsets, STATUS bit positions,
// FSM state encodings (common to TX and RX) and the divisor floor.
package uart_defs;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int unsigned STAT_TX_BUSY   = 0;
  localparam int unsigned STAT_RX_VALID  = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;
  localparam int unsigned STAT_CLEAR     = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] MIN_DIV = 16'd4;

  // Divisor as actually used for timing; the register keeps the raw value.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_top_if.sv
// 8-bit peripheral bus as seen by one peripheral window.
interface uart_top_if;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;

  modport master (output addr, output dout, output wr_en, output rd_en, input din);
  modport slave  (input addr, input dout, input wr_en, input rd_en, output din);
endinterface

// File: rtl/uart_rx_core.sv
// RX path: 2-flop synchronizer, start/data/stop FSM, bit counter and shift register.
// byte_done is a one-cycle pulse at the stop-bit sample; data_byte/stop_err are valid with it.
module uart_rx_core
  import uart_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] div,
  output logic        byte_done,
  output logic [7:0]  data_byte,
  output logic        stop_err
);

  logic [1:0]  sync;
  logic        rx_s;
  logic        rx_prev;
  logic [1:0]  state;
  logic [15:0] bit_div;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [16:0] div_p1;
  logic [15:0] half_pt;
  logic        sample;

  assign rx_s    = sync[1];
  assign div_p1  = {1'b0, bit_div} + 17'd1;
  assign half_pt = div_p1[16:1] - 16'd1;
  // Start bit is checked mid-bit; every later sample is one full bit period on.
  assign sample  = (state == S_START) ? (cnt == half_pt) : (cnt == bit_div);

  assign byte_done = (state == S_STOP) && sample;
  assign data_byte = shift;
  assign stop_err  = ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      state   <= S_IDLE;
      bit_div <= MIN_DIV;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
      if (state == S_IDLE) begin
        if (rx_prev && !rx_s) begin
          state   <= S_START;
          bit_div <= div;
          cnt     <= '0;
        end
      end else if (sample) begin
        cnt <= '0;
        case (state)
          S_START: begin
            if (rx_s) state <= S_IDLE;
            else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
          S_DATA: begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_top.sv
// Memory-mapped 8N1 UART: STATUS/DATA/DIV_LO/DIV_HI window, TX FSM and RX flag registers.
// din is zero outside a read of this window so the SoC can OR peripheral read buses.
module uart_top
  import uart_defs::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hA0,
  parameter logic [7:0]  LAST_ADDR   = 8'hA3,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic       clk,
  input  logic       reset,
  uart_top_if.slave  bus,
  output logic       tx,
  input  logic       rx
);

  logic [7:0]  off;
  logic        in_win;
  logic        sel_status, sel_data, sel_div_lo, sel_div_hi;
  logic        wr_data, rd_data;
  logic [15:0] div_reg, div_eff;
  logic [1:0]  tx_state;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun, frame_err;
  logic        byte_done, stop_err;
  logic [7:0]  data_byte;
  logic [7:0]  status;

  assign off        = bus.addr - BASE_ADDR;
  assign in_win     = (bus.addr >= BASE_ADDR) && (bus.addr <= LAST_ADDR);
  assign sel_status = in_win && (off == {6'b0, REG_STATUS});
  assign sel_data   = in_win && (off == {6'b0, REG_DATA});
  assign sel_div_lo = in_win && (off == {6'b0, REG_DIV_LO});
  assign sel_div_hi = in_win && (off == {6'b0, REG_DIV_HI});
  assign wr_data    = bus.wr_en && sel_data;
  assign rd_data    = bus.rd_en && sel_data;
  assign div_eff    = eff_div(div_reg);
  assign tx_busy    = (tx_state != S_IDLE);

  always_comb begin
    status                 = '0;
    status[STAT_TX_BUSY]   = tx_busy;
    status[STAT_RX_VALID]  = rx_valid;
    status[STAT_OVERRUN]   = overrun;
    status[STAT_FRAME_ERR] = frame_err;
  end

  always_comb begin
    bus.din = '0;
    if (bus.rd_en) begin
      if (sel_status) bus.din = status;
      if (sel_data)   bus.din = rx_data;
      if (sel_div_lo) bus.din = div_reg[7:0];
      if (sel_div_hi) bus.din = div_reg[15:8];
    end
  end

  // tx is registered and updated on state transitions so each level lasts exactly tx_div+1 clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_div   <= MIN_DIV;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_state == S_IDLE) begin
      if (wr_data) begin
        tx_state <= S_START;
        tx       <= 1'b0;
        tx_div   <= div_eff;
        tx_shift <= bus.dout;
        tx_cnt   <= '0;
      end
    end else if (tx_cnt == tx_div) begin
      tx_cnt <= '0;
      case (tx_state)
        S_START: begin
          tx_state <= S_DATA;
          tx       <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= '0;
        end
        S_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP;
            tx       <= 1'b1;
          end else begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  // Later assignments win: byte completion overrides both the STATUS clear and the DATA-read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= DEFAULT_DIV;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (bus.wr_en && sel_div_lo) div_reg[7:0]  <= bus.dout;
      if (bus.wr_en && sel_div_hi) div_reg[15:8] <= bus.dout;
      if (bus.wr_en && sel_status && bus.dout[STAT_CLEAR]) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rd_data) rx_valid <= 1'b0;
      if (byte_done) begin
        rx_data  <= data_byte;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_data) overrun <= 1'b1;
        if (stop_err) frame_err <= 1'b1;
      end
    end
  end

  uart_rx_core u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .div       (div_eff),
    .byte_done (byte_done),
    .data_byte (data_byte),
    .stop_err  (stop_err)
  );

endmodule

// File: tb/tb_uart_top.sv
// Randomized self-checking bench for uart_top against a frame-level UART model.
module tb_uart_top;

  logic clk;
  logic reset;
  logic tx;
  logic rx;

  uart_top_if bus ();

  uart_top #(
    .BASE_ADDR   (8'hA0),
    .LAST_ADDR   (8'hA3),
    .DEFAULT_DIV (16'd15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .rx    (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_div;
  logic        m_valid, m_ovr, m_ferr;
  logic [7:0]  m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned bit_clks(input int unsigned div);
    return ((div < 4) ? 4 : div) + 1;
  endfunction

  function automatic logic [7:0] exp_status();
    return {4'b0, m_ferr, m_ovr, m_valid, 1'b0};
  endfunction

  task automatic model_reset();
    m_div   = 15;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.dout  = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1;
    check(tag, bus.din, exp);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic set_div(input int unsigned div);
    bus_write(8'hA2, div[7:0]);
    bus_write(8'hA3, div[15:8]);
    m_div = div;
  endtask

  task automatic read_data();
    bus_read(8'hA1, m_data, "rx_data");
    m_valid = 1'b0;
  endtask

  // Sends one byte on tx and checks every clock of the line and tx_busy.
  task automatic tx_frame(input logic [7:0] b, input bit intrude);
    int unsigned d, total;
    logic [9:0] frame;
    d     = bit_clks(m_div);
    total = 10 * d;
    frame = {1'b1, b, 1'b0};
    bus_write(8'hA1, b);
    bus.addr  = 8'hA0;
    bus.rd_en = 1'b1;
    for (int unsigned i = 0; i <= total; i++) begin
      #1;
      check("tx_line", tx, (i < total) ? 32'(frame[i / d]) : 32'd1);
      check("tx_busy", bus.din[0], (i < total) ? 32'd1 : 32'd0);
      if (intrude && i == 3 * d + 2) begin
        bus.rd_en = 1'b0;
        bus.addr  = 8'hA1;
        bus.dout  = ~b;
        bus.wr_en = 1'b1;
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.addr  = 8'hA0;
      bus.rd_en = 1'b1;
    end
    bus.rd_en = 1'b0;
  endtask

  // Drives one frame into rx at the current bit period and checks rx_valid latency.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    int unsigned d, lat;
    int rise;
    logic was_valid;
    logic [9:0] frame;
    d         = bit_clks(m_div);
    lat       = 2 + d / 2 + 9 * d;
    frame     = {stop_bit, b, 1'b0};
    rise      = -1;
    was_valid = m_valid;
    @(negedge clk);
    bus.addr  = 8'hA0;
    bus.rd_en = 1'b1;
    for (int unsigned c = 0; c < 12 * d; c++) begin
      rx = (c < 10 * d) ? frame[c / d] : 1'b1;
      #1;
      if (rise < 0 && bus.din[1] === 1'b1) rise = int'(c);
      @(negedge clk);
    end
    rx        = 1'b1;
    bus.rd_en = 1'b0;
    if (!was_valid)
      check("rx_latency", (rise >= int'(lat) - 1) && (rise <= int'(lat) + 1), 1);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
    if (!stop_bit) m_ferr = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       sb;
    reset     = 1'b1;
    rx        = 1'b1;
    bus.addr  = 8'h00;
    bus.dout  = 8'h00;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("reset_tx", tx, 1);
    end
    reset = 1'b0;

    // Reset values and read-bus isolation
    bus_read(8'hA0, 8'h00, "reset_status");
    bus_read(8'hA2, 8'h0F, "reset_div_lo");
    bus_read(8'hA3, 8'h00, "reset_div_hi");
    bus_read(8'hA4, 8'h00, "out_of_window_hi");
    bus_read(8'h9F, 8'h00, "out_of_window_lo");
    @(negedge clk);
    bus.addr = 8'hA2;
    #1;
    check("din_no_rd", bus.din, 0);
    check("idle_tx", tx, 1);

    // TX at DIV=15 with an ignored write mid-frame, then random bytes and divisors
    tx_frame(8'h55, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_div($urandom_range(4, 9));
      bus_read(8'hA2, m_div[7:0], "div_lo_readback");
      tx_frame(8'($urandom), k == 1);
    end
    set_div(2);
    tx_frame(8'($urandom), 1'b0);

    // RX at 16 clocks per bit
    set_div(15);
    rx_frame(8'hA3, 1'b1);
    bus_read(8'hA0, exp_status(), "status_rx_valid");
    read_data();
    bus_read(8'hA0, exp_status(), "status_after_read");

    // Overrun and clear
    rx_frame(8'($urandom), 1'b1);
    rx_frame(8'($urandom), 1'b1);
    bus_read(8'hA0, exp_status(), "status_overrun");
    read_data();
    bus_write(8'hA0, 8'h80);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    bus_read(8'hA0, exp_status(), "status_cleared");

    // Framing error still delivers the byte
    rx_frame(8'h3C, 1'b0);
    bus_read(8'hA0, exp_status(), "status_frame_err");
    read_data();
    bus_write(8'hA0, 8'h80);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;

    // False start: short low glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(8'hA0, exp_status(), "status_false_start");

    // Random RX traffic with random divisors, stop bits and read-back choices
    for (int k = 0; k < 5; k++) begin
      set_div($urandom_range(4, 12));
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      rx_frame(b, sb);
      bus_read(8'hA0, exp_status(), "status_rand");
      if ($urandom_range(0, 1) == 1) read_data();
      if ($urandom_range(0, 2) == 0) begin
        bus_write(8'hA0, 8'h80);
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
    end
    read_data();

    // Reset in the middle of a TX frame
    set_div(15);
    bus_write(8'hA1, 8'h00);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_tx_line", tx, 1);
    model_reset();
    bus_read(8'hA0, 8'h00, "reset_mid_tx_status");
    reset = 1'b0;
    bus_read(8'hA0, exp_status(), "post_reset_status");
    bus_read(8'hA2, 8'h0F, "post_reset_div");
    @(negedge clk);
    check("post_reset_tx", tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
